// File: rtl/int_request_ctrl.sv
// Device-side interrupt request controller: latches device events, picks the highest
// pending source, drives the datapath interrupt request and returns the ISR result.
module int_request_ctrl #(
    parameter int DATA_W      = 16,
    parameter int REQ_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [3:0]            devReq,
    input  logic [4*DATA_W-1:0]   devData,
    output logic                  intWrite,
    output logic [DATA_W-1:0]     intDataIn,
    output logic                  int0,
    output logic                  int1,
    output logic                  intLvl1,
    output logic                  intLvl0,
    input  logic                  intr,
    input  logic [DATA_W-1:0]     intDataOut,
    output logic [3:0]            devAck,
    output logic [DATA_W-1:0]     devRetData,
    output logic                  devRetValid,
    output logic                  dropErr,
    output logic                  busy
);

    localparam int CNT_W = $clog2(REQ_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, REQ, SERVICE} state_t;

    state_t            state, state_next;
    logic [3:0]        req_sync, req_prev, rise, pending, clr_mask, src_onehot;
    logic [1:0]        src, winner;
    logic [DATA_W-1:0] payload, data_q;
    logic [CNT_W-1:0]  req_cnt;
    logic              intr_prev, repend, timeout, done;

    assign rise       = req_sync & ~req_prev;
    assign src_onehot = 4'b0001 << src;
    assign timeout    = (state == REQ) && !intr && (req_cnt == CNT_W'(REQ_TIMEOUT - 1));
    assign done       = (state == SERVICE) && intr_prev && !intr;
    // A fresh edge from the serviced source during SERVICE must survive the completion clear.
    assign clr_mask   = (timeout || (done && !repend)) ? src_onehot : 4'b0000;
    assign payload    = devData[winner*DATA_W +: DATA_W];

    always_comb begin
        winner = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending[i]) winner = 2'(i);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|pending) state_next = LOAD;
            LOAD:    state_next = REQ;
            REQ:     if (intr) state_next = SERVICE;
                     else if (timeout) state_next = IDLE;
            SERVICE: if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        intWrite  = (state == LOAD);
        int1      = (state == REQ) && src[1];
        int0      = (state == REQ) && !src[1];
        intLvl1   = (state != IDLE) && src[1];
        intLvl0   = (state != IDLE) && src[0];
        busy      = (state != IDLE);
        intDataIn = data_q;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            req_sync    <= '0;
            req_prev    <= '0;
            pending     <= '0;
            src         <= '0;
            data_q      <= '0;
            req_cnt     <= '0;
            intr_prev   <= 1'b0;
            repend      <= 1'b0;
            devAck      <= '0;
            devRetValid <= 1'b0;
            dropErr     <= 1'b0;
            devRetData  <= '0;
        end else begin
            req_sync    <= devReq;
            req_prev    <= req_sync;
            intr_prev   <= intr;
            pending     <= (pending & ~clr_mask) | rise;
            devAck      <= done ? src_onehot : 4'b0000;
            devRetValid <= done;
            dropErr     <= timeout;
            if (done) devRetData <= intDataOut;
            if (state == IDLE && |pending) begin
                src    <= winner;
                data_q <= payload;
            end
            if (state == REQ) req_cnt <= req_cnt + 1'b1;
            else              req_cnt <= '0;
            if (state == REQ)                              repend <= 1'b0;
            else if (state == SERVICE && |(rise & src_onehot)) repend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_int_request_ctrl.sv
// Directed bench for int_request_ctrl: expected writes and return values are queued when
// stimulus is driven and compared when the controller produces them.
module tb_int_request_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  devReq;
    logic [63:0] devData;
    logic        intWrite;
    logic [15:0] intDataIn;
    logic        int0, int1, intLvl1, intLvl0;
    logic        intr;
    logic [15:0] intDataOut;
    logic [3:0]  devAck;
    logic [15:0] devRetData;
    logic        devRetValid, dropErr, busy;

    typedef struct {
        logic [1:0]  src;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] ret_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 CLK = ~CLK;

    int_request_ctrl #(.DATA_W(16), .REQ_TIMEOUT(64)) dut (
        .CLK(CLK), .Reset(Reset), .devReq(devReq), .devData(devData),
        .intWrite(intWrite), .intDataIn(intDataIn), .int0(int0), .int1(int1),
        .intLvl1(intLvl1), .intLvl0(intLvl0), .intr(intr), .intDataOut(intDataOut),
        .devAck(devAck), .devRetData(devRetData), .devRetValid(devRetValid),
        .dropErr(dropErr), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int s, input logic [15:0] d);
        wr_t w;
        devData[s*16 +: 16] = d;
        devReq[s] = 1'b1;
        w.src = 2'(s);
        w.data = d;
        wr_q.push_back(w);
    endtask

    // Waits (bounded) for the write strobe, then compares it against the oldest expected write.
    task automatic wait_write(input int exp_lat);
        wr_t w;
        int  n = 0;
        while (!intWrite && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("write_seen", {31'd0, intWrite}, 32'd1);
        if (exp_lat >= 0) check("write_latency", n, exp_lat);
        if (wr_q.size() == 0) begin
            check("write_expected", 32'd1, 32'd0);
        end else begin
            w = wr_q.pop_front();
            check("write_data", {16'd0, intDataIn}, {16'd0, w.data});
            check("write_lvl", {30'd0, intLvl1, intLvl0}, {30'd0, w.src});
        end
    endtask

    // Called on the LOAD cycle: answers the request, holds intr, returns ret and checks the ack.
    task automatic svc(input int s, input int hold, input logic [15:0] ret, input bit repend);
        logic [1:0]  s2 = 2'(s);
        logic [15:0] exp;
        int          n = 0;
        @(negedge CLK);
        check("req_int", {30'd0, int1, int0}, {30'd0, s2[1], ~s2[1]});
        check("req_lvl", {30'd0, intLvl1, intLvl0}, {30'd0, s2});
        intr = 1'b1;
        @(negedge CLK);
        check("svc_int_low", {30'd0, int1, int0}, 32'd0);
        check("svc_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < hold - 1; i++) begin
            if (repend && i == 1) devReq[s] = 1'b0;
            if (repend && i == 3) set_req(s, devData[s*16 +: 16]);
            @(negedge CLK);
        end
        check("svc_lvl_held", {30'd0, intLvl1, intLvl0}, {30'd0, s2});
        intr = 1'b0;
        intDataOut = ret;
        ret_q.push_back(ret);
        while (!devRetValid && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("ret_valid", {31'd0, devRetValid}, 32'd1);
        exp = (ret_q.size() != 0) ? ret_q.pop_front() : 16'hxxxx;
        check("ret_data", {16'd0, devRetData}, {16'd0, exp});
        check("ret_ack", {28'd0, devAck}, 32'd1 << s);
        @(negedge CLK);
        check("ret_pulse_end", {27'd0, devRetValid, devAck}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        Reset = 1'b0;
        devReq = '0;
        devData = '0;
        intr = 1'b0;
        intDataOut = '0;

        repeat (2) @(negedge CLK);
        check("reset_outs", {20'd0, intWrite, int0, int1, intLvl1, intLvl0, devAck,
                             devRetValid, dropErr, busy}, 32'd0);
        check("reset_retdata", {16'd0, devRetData}, 32'd0);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_after_reset", {30'd0, busy, intWrite}, 32'd0);

        $display("[TB] single low-priority request");
        set_req(1, 16'hA5A5);
        wait_write(3);
        svc(1, 4, 16'h1234, 1'b0);
        devReq = '0;
        repeat (3) @(negedge CLK);

        $display("[TB] simultaneous requests 0 and 3");
        set_req(3, 16'h3333);
        set_req(0, 16'h0F0F);
        wait_write(3);
        svc(3, 2, 16'hC3C3, 1'b0);
        wait_write(0);
        svc(0, 3, 16'h0C0C, 1'b0);
        devReq = '0;
        repeat (3) @(negedge CLK);

        $display("[TB] request timeout");
        set_req(2, 16'h2222);
        wait_write(3);
        n = 0;
        while (!dropErr && n < 100) begin
            @(negedge CLK);
            n++;
            if (n == 64) check("req_last_cycle", {31'd0, int1}, 32'd1);
        end
        check("drop_latency", n, 32'd65);
        check("drop_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        check("drop_pulse_end", {31'd0, dropErr}, 32'd0);
        repeat (4) @(negedge CLK);
        check("drop_pending_clear", {31'd0, busy}, 32'd0);
        devReq = '0;
        repeat (3) @(negedge CLK);

        $display("[TB] re-request during service");
        set_req(2, 16'h5A5A);
        wait_write(3);
        devData[47:32] = 16'h6B6B;
        svc(2, 8, 16'hBEEF, 1'b1);
        wait_write(0);
        svc(2, 2, 16'h0101, 1'b0);
        devReq = '0;
        repeat (3) @(negedge CLK);

        $display("[TB] reset during service");
        set_req(1, 16'h7777);
        wait_write(3);
        @(negedge CLK);
        check("pre_reset_int0", {31'd0, int0}, 32'd1);
        intr = 1'b1;
        repeat (2) @(negedge CLK);
        #2 Reset = 1'b0;
        #1;
        check("async_reset_outs", {26'd0, int0, int1, intLvl1, intLvl0, busy, intWrite}, 32'd0);
        check("async_reset_retdata", {16'd0, devRetData}, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        intr = 1'b0;
        intDataOut = 16'hFFFF;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (devRetValid || devAck != 4'd0) pulses++;
        end
        check("no_ack_after_reset", pulses, 32'd0);
        check("scoreboard_empty", wr_q.size() + ret_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
